// File: rtl/cdc_handshake_tx.sv
// ============================================================================
//  Module   : cdc_handshake_tx
//  Purpose  : Source half of a 2-phase toggle CDC handshake with a one-entry
//             pending buffer and a completed-transfer counter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module cdc_handshake_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   arst_ni,
    input  logic                   dff0_clk_in,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  cdc_data_o,
    output logic                   cdc_req_o,
    input  logic                   cdc_ack_i,
    output logic                   busy_o,
    output logic [COUNT_WIDTH-1:0] xfer_count_o
);

    logic                   r_ack_s1;
    logic                   r_ack_s2;
    logic                   r_req;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_pend_valid;
    logic [DATA_WIDTH-1:0]  r_pend_data;
    logic [COUNT_WIDTH-1:0] r_count;

    logic w_busy;
    logic w_complete;
    logic w_accept;
    logic w_launch_pend;
    logic w_launch_in;
    logic w_store;

    assign w_busy = r_req ^ r_ack_s2;

    // Completion is taken on the edge where the synchronized ack catches up
    // with req, so the next word can launch on that very edge.
    assign w_complete    = w_busy & (r_ack_s1 == r_req);
    assign w_accept      = valid_i & ~r_pend_valid;
    assign w_launch_pend = w_complete & r_pend_valid;
    assign w_launch_in   = w_accept & (~w_busy | w_complete);
    assign w_store       = w_accept & w_busy & ~w_complete;

    always_ff @(posedge dff0_clk_in or negedge arst_ni) begin
        if (!arst_ni) begin
            r_ack_s1     <= 1'b0;
            r_ack_s2     <= 1'b0;
            r_req        <= 1'b0;
            r_data       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_count      <= '0;
        end else begin
            r_ack_s1 <= cdc_ack_i;
            r_ack_s2 <= r_ack_s1;
            if (w_complete) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
            // A pending word can only exist while the producer is blocked,
            // so the three cases below are mutually exclusive.
            if (w_launch_pend) begin
                r_data       <= r_pend_data;
                r_req        <= ~r_req;
                r_pend_valid <= 1'b0;
            end else if (w_launch_in) begin
                r_data <= data_i;
                r_req  <= ~r_req;
            end else if (w_store) begin
                r_pend_data  <= data_i;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign ready_o      = ~r_pend_valid;
    assign cdc_data_o   = r_data;
    assign cdc_req_o    = r_req;
    assign busy_o       = w_busy;
    assign xfer_count_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
// ============================================================================
//  Module   : tb_cdc_handshake_tx
//  Purpose  : Self-checking bench for cdc_handshake_tx with a transaction-level
//             model and a loopback destination on an unrelated clock.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cdc_handshake_tx;

    logic        clk     = 1'b0;
    logic        dclk    = 1'b0;
    logic        arst_ni = 1'b0;
    logic [7:0]  data_i  = 8'h00;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  cdc_data_o;
    logic        cdc_req_o;
    logic        cdc_ack_i;
    logic        busy_o;
    logic [15:0] xfer_count_o;

    logic        loop_en = 1'b0;
    logic        man_ack = 1'b0;
    logic [2:0]  dreq;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    assign cdc_ack_i = loop_en ? dreq[2] : man_ack;

    cdc_handshake_tx #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .arst_ni      (arst_ni),
        .dff0_clk_in  (clk),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .cdc_data_o   (cdc_data_o),
        .cdc_req_o    (cdc_req_o),
        .cdc_ack_i    (cdc_ack_i),
        .busy_o       (busy_o),
        .xfer_count_o (xfer_count_o)
    );

    initial forever #5 clk = ~clk;
    initial begin
        #2 dclk = 1'b1;
        forever #7 dclk = ~dclk;
    end

    // Transaction-level model: one word in flight, at most one waiting, and
    // every ack toggle that has crossed the two-flop delay retires a word.
    typedef struct packed {
        logic        inf;
        logic        pv;
        logic        req;
        logic [7:0]  pd;
        logic [7:0]  data;
        logic [15:0] cnt;
    } mstate_t;

    mstate_t    m;
    logic       a1, a2;
    int         m_acc_cnt = 0;
    logic [7:0] sent[$];
    logic [7:0] rcv[$];

    function automatic mstate_t step(input mstate_t s, input logic done,
                                     input logic acc, input logic [7:0] d);
        mstate_t n = s;
        if (done && n.inf) begin
            n.cnt = n.cnt + 16'd1;
            n.inf = 1'b0;
            if (n.pv) begin
                n.data = n.pd;
                n.req  = ~n.req;
                n.inf  = 1'b1;
                n.pv   = 1'b0;
            end
        end
        if (acc) begin
            if (n.inf) begin
                n.pv = 1'b1;
                n.pd = d;
            end else begin
                n.data = d;
                n.req  = ~n.req;
                n.inf  = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            m  <= '0;
            a1 <= 1'b0;
            a2 <= 1'b0;
        end else begin
            m  <= step(m, a1 != a2, valid_i && !m.pv, data_i);
            a2 <= a1;
            a1 <= cdc_ack_i;
            if (valid_i && !m.pv) begin
                sent.push_back(data_i);
                m_acc_cnt <= m_acc_cnt + 1;
            end
        end
    end

    // Destination: 2-flop req sync, capture on synced change, ack one flop later.
    always @(posedge dclk or negedge arst_ni) begin
        if (!arst_ni) begin
            dreq <= '0;
        end else begin
            dreq <= {dreq[1:0], cdc_req_o};
            if (loop_en && (dreq[1] != dreq[2])) rcv.push_back(cdc_data_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    logic        p_busy = 1'b0;
    logic [7:0]  p_data = 8'h00;
    logic [15:0] p_cnt  = 16'h0000;

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("ready", ready_o, !m.pv);
            check("busy", busy_o, m.inf);
            check("req", cdc_req_o, m.req);
            check("data", cdc_data_o, m.data);
            check("count", xfer_count_o, m.cnt);
            if (p_busy && busy_o && xfer_count_o == p_cnt)
                check("stable", cdc_data_o, p_data);
        end
        p_busy = busy_o;
        p_data = cdc_data_o;
        p_cnt  = xfer_count_o;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int c = 0;
        while ((busy_o || m.inf) && c < maxc) begin
            tick();
            c++;
        end
        check(nm, 32'(c < maxc), 32'd1);
    endtask

    initial begin
        int s0, r0, target;

        repeat (2) tick();
        check("rst_req", cdc_req_o, 0);
        check("rst_data", cdc_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_count", xfer_count_o, 0);
        chk_en  = 1'b1;
        arst_ni = 1'b1;
        repeat (2) tick();

        // Bypass launch from idle, then manual ack
        data_i = 8'hA5; valid_i = 1'b1; tick(); valid_i = 1'b0;
        check("t2_data", cdc_data_o, 8'hA5);
        check("t2_req", cdc_req_o, 1);
        check("t2_busy", busy_o, 1);
        man_ack = 1'b1; tick();
        check("t2_busy_1edge", busy_o, 1);
        tick();
        check("t2_idle", busy_o, 0);
        check("t2_count", xfer_count_o, 1);

        // Pending word held while busy, launched on completion
        data_i = 8'hA5; valid_i = 1'b1; tick();
        data_i = 8'h3C; tick(); valid_i = 1'b0;
        check("t3_ready", ready_o, 0);
        check("t3_hold", cdc_data_o, 8'hA5);
        man_ack = 1'b0; tick();
        check("t3_hold2", cdc_data_o, 8'hA5);
        tick();
        check("t3_data", cdc_data_o, 8'h3C);
        check("t3_req", cdc_req_o, 1);
        check("t3_ready1", ready_o, 1);
        check("t3_count", xfer_count_o, 2);

        // Accept coincides with completion, pending empty
        man_ack = 1'b1; tick();
        data_i = 8'h77; valid_i = 1'b1; tick(); valid_i = 1'b0;
        check("t4_data", cdc_data_o, 8'h77);
        check("t4_busy", busy_o, 1);
        check("t4_ready", ready_o, 1);
        check("t4_count", xfer_count_o, 3);
        man_ack = 1'b0; repeat (3) tick();
        check("t4_idle", busy_o, 0);
        check("t4_count2", xfer_count_o, 4);

        // Randomized loopback traffic
        repeat (6) tick();
        loop_en = 1'b1;
        s0 = sent.size();
        target = m_acc_cnt + 1000;
        for (int cyc = 0; cyc < 40000 && m_acc_cnt < target; cyc++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = 8'($urandom);
            tick();
        end
        valid_i = 1'b0;
        check("rand_accepted", m_acc_cnt, target);
        wait_idle(200, "rand_drain");
        repeat (6) tick();
        check("rand_count", xfer_count_o, 16'd1004);
        check("rx_size", rcv.size(), 1000);
        for (int i = 0; i < rcv.size() && i < 1000; i++)
            check("rx_seq", rcv[i], sent[s0 + i]);

        // Asynchronous reset with a word in flight and one pending
        man_ack = cdc_ack_i;
        loop_en = 1'b0;
        data_i = 8'hB1; valid_i = 1'b1; tick();
        data_i = 8'hB2; tick(); valid_i = 1'b0;
        check("t6_ready", ready_o, 0);
        check("t6_data", cdc_data_o, 8'hB1);
        #2 arst_ni = 1'b0;
        #1;
        check("t6_rst_req", cdc_req_o, 0);
        check("t6_rst_data", cdc_data_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_ready", ready_o, 1);
        check("t6_rst_count", xfer_count_o, 0);
        man_ack = 1'b0;
        loop_en = 1'b1;
        r0 = rcv.size();
        repeat (2) tick();
        arst_ni = 1'b1;
        repeat (2) tick();
        data_i = 8'h11; valid_i = 1'b1; tick(); valid_i = 1'b0;
        check("t6_launch", cdc_data_o, 8'h11);
        wait_idle(50, "t6_drain");
        check("t6_count", xfer_count_o, 1);
        if (rcv.size() > r0) check("t6_rx", rcv[r0], 8'h11);
        else check("t6_rx_size", rcv.size(), r0 + 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
